// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
//
// Feeds a program image into the instruction memory of the single-cycle RV32I
// core, and holds the core in reset until the whole image has been written.
//
// Stream format (one byte per beat, beat = rx_valid & rx_ready):
//   N[7:0], N[15:8], then 4*N instruction bytes, least significant byte first.
// Each group of four bytes is packed into one little-endian 32-bit word and
// written to consecutive word addresses starting at 0.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high; rx_ready is held low while asserted
//   rx_data      stream byte
//   rx_valid     rx_data is valid
//   rx_ready     loader can accept a byte (header and load phases)
//   imem_we      single-cycle instruction memory write strobe
//   imem_addr    word address of the write (holds when imem_we is low)
//   imem_wdata   instruction word (holds when imem_we is low)
//   cpu_reset    core reset; high until the image is completely loaded
//   load_done    image loaded, core released
//   load_error   header word count larger than IMEM_DEPTH
//   words_loaded number of words written since the last reset
// -----------------------------------------------------------------------------
module imem_boot_loader #(
  parameter int IMEM_DEPTH = 64,
  parameter int ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    ST_HDR_LO = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_LOAD   = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

  localparam logic [15:0] DEPTH_W = 16'(IMEM_DEPTH);

  state_t              state_q, state_d;
  logic [7:0]          n_lo_q, n_lo_d;
  logic [15:0]         n_q, n_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  // Lanes 0..2 of the word being assembled; lane 3 comes straight from rx_data.
  logic [23:0]         lanes_q, lanes_d;
  // One bit wider than the address so it can reach IMEM_DEPTH without wrapping.
  logic [ADDR_W:0]     word_idx_q, word_idx_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;

  logic                active;
  logic                beat;
  logic [15:0]         n_hdr;
  logic                load_complete;

  // The loader only listens in the header and load phases, never in reset.
  assign active   = (state_q == ST_HDR_LO) || (state_q == ST_HDR_HI) ||
                    (state_q == ST_LOAD);
  assign rx_ready = active && !reset;
  assign beat     = rx_valid && rx_ready;
  assign n_hdr    = {rx_data, n_lo_q};

  // The final write is visible this cycle; the FSM leaves LOAD on the next
  // edge, so cpu_reset drops one cycle after the last imem_we.
  assign load_complete = imem_we_q && (16'(word_idx_q) == n_q);

  always_comb begin
    state_d      = state_q;
    n_lo_d       = n_lo_q;
    n_d          = n_q;
    byte_idx_d   = byte_idx_q;
    lanes_d      = lanes_q;
    word_idx_d   = word_idx_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    case (state_q)
      ST_HDR_LO: begin
        if (beat) begin
          n_lo_d  = rx_data;
          state_d = ST_HDR_HI;
        end
      end

      ST_HDR_HI: begin
        if (beat) begin
          n_d        = n_hdr;
          byte_idx_d = 2'd0;
          if (n_hdr == 16'd0) begin
            state_d = ST_DONE;
          end else if (n_hdr > DEPTH_W) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (load_complete) begin
          // A byte offered in this last cycle is handshaken but belongs to
          // no word of the image, so it is dropped.
          state_d = ST_DONE;
        end else if (beat) begin
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: lanes_d[7:0]   = rx_data;
            2'd1: lanes_d[15:8]  = rx_data;
            2'd2: lanes_d[23:16] = rx_data;
            2'd3: begin
              imem_we_d    = 1'b1;
              imem_addr_d  = word_idx_q[ADDR_W-1:0];
              imem_wdata_d = {rx_data, lanes_q};
              word_idx_d   = word_idx_q + 1'b1;
            end
            default: ;
          endcase
        end
      end

      ST_DONE: ;
      ST_ERR:  ;
      default: state_d = ST_HDR_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_HDR_LO;
      n_lo_q       <= '0;
      n_q          <= '0;
      byte_idx_q   <= '0;
      lanes_q      <= '0;
      word_idx_q   <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      n_lo_q       <= n_lo_d;
      n_q          <= n_d;
      byte_idx_q   <= byte_idx_d;
      lanes_q      <= lanes_d;
      word_idx_q   <= word_idx_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
    end
  end

  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign cpu_reset    = (state_q != ST_DONE);
  assign load_done    = (state_q == ST_DONE);
  assign load_error   = (state_q == ST_ERR);
  // Every written word advances the word index, so it doubles as the count.
  assign words_loaded = word_idx_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          load_done;
  logic          load_error;
  logic [AW:0]   words_loaded;

  imem_boot_loader #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_reset    (cpu_reset),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests  = 0;
  int failed = 0;

  logic [7:0] stream_q[$];
  int         beat_q[$];

  // Write monitor: records every write strobe and the first cycle the core
  // is released. Cleared whenever clr_gen changes.
  logic [AW-1:0] wr_addr_q[$];
  logic [31:0]   wr_data_q[$];
  int            wr_cyc_q[$];
  int            done_cyc = -1;
  int            clr_gen  = 0;
  int            seen_gen = 0;

  always @(negedge clk) begin
    if (seen_gen != clr_gen) begin
      seen_gen = clr_gen;
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_cyc_q.delete();
      done_cyc = -1;
    end
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
      wr_cyc_q.push_back(cyc);
      $display("[TB] write addr %0d data %08h cycle %0d", imem_addr, imem_wdata, cyc);
    end
    if (cpu_reset === 1'b0 && done_cyc < 0) done_cyc = cyc;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic apply_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    @(posedge clk); #1;
    chk("rst rx_ready", {31'd0, rx_ready}, 32'd0);
    clr_gen++;
    beat_q.delete();
    @(posedge clk); #1;
    chk("rst imem_we",      {31'd0, imem_we},    32'd0);
    chk("rst imem_addr",    32'(imem_addr),      32'd0);
    chk("rst imem_wdata",   imem_wdata,          32'd0);
    chk("rst cpu_reset",    {31'd0, cpu_reset},  32'd1);
    chk("rst flags",        {30'd0, load_done, load_error}, 32'd0);
    chk("rst words_loaded", 32'(words_loaded),   32'd0);
    reset = 1'b0;
    #1;
  endtask

  // Offers the first 'count' bytes of stream_q with random idle gaps.
  task automatic send_n(input int count, input int max_gap, output bit ok);
    int gap;
    int w;
    ok = 1'b1;
    for (int i = 0; i < count; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      rx_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        rx_data = 8'($urandom);
        @(posedge clk); #1;
      end
      rx_valid = 1'b1;
      rx_data  = stream_q[i];
      w = 0;
      while (rx_ready !== 1'b1 && w <= 20) begin
        @(posedge clk); #1;
        w++;
      end
      if (rx_ready !== 1'b1) begin
        tests++;
        failed++;
        $display("FAIL handshake: byte %0d not accepted, rx_ready=%b expected 1", i, rx_ready);
        ok = 1'b0;
        rx_valid = 1'b0;
        return;
      end
      beat_q.push_back(cyc);
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
  endtask

  // Offers bytes after a terminal state: nothing may be accepted or written.
  task automatic hold_check(input int cycles, input int exp_words, input bit exp_done, input bit exp_err);
    rx_valid = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      rx_data = 8'($urandom);
      chk("hold rx_ready", {31'd0, rx_ready}, 32'd0);
      chk("hold imem_we",  {31'd0, imem_we},  32'd0);
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    chk("hold words_loaded", 32'(words_loaded), 32'(exp_words));
    chk("hold load_done",    {31'd0, load_done},  {31'd0, exp_done});
    chk("hold load_error",   {31'd0, load_error}, {31'd0, exp_err});
    chk("hold cpu_reset",    {31'd0, cpu_reset},  {31'd0, !exp_done});
  endtask

  task automatic build_stream(input int n, input int body_words);
    stream_q.delete();
    stream_q.push_back(8'(n));
    stream_q.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * body_words; i++) stream_q.push_back(8'($urandom));
  endtask

  // Sends stream_q and compares against the image the stream describes:
  // word i = bytes 2+4i..5+4i little-endian at address i, each written one
  // cycle after its fourth byte, core released one cycle after the last write
  // (or one cycle after the header for an empty image).
  task automatic run_check(input string name, input int max_gap, input bit exp_done,
                           input bit exp_err, input int exp_words);
    bit ok;
    logic [31:0] exp_word;
    int exp_done_cyc;
    send_n(stream_q.size(), max_gap, ok);
    repeat (3) begin @(posedge clk); #1; end
    chk({name, " write count"}, 32'(wr_addr_q.size()), 32'(exp_words));
    if (ok) begin
      for (int i = 0; i < exp_words && i < wr_addr_q.size(); i++) begin
        exp_word = {stream_q[5+4*i], stream_q[4+4*i], stream_q[3+4*i], stream_q[2+4*i]};
        chk({name, " addr"},  32'(wr_addr_q[i]), 32'(i));
        chk({name, " data"},  wr_data_q[i], exp_word);
        chk({name, " wcyc"},  32'(wr_cyc_q[i]), 32'(beat_q[5+4*i] + 1));
      end
    end
    chk({name, " load_done"},    {31'd0, load_done},  {31'd0, exp_done});
    chk({name, " load_error"},   {31'd0, load_error}, {31'd0, exp_err});
    chk({name, " cpu_reset"},    {31'd0, cpu_reset},  {31'd0, !exp_done});
    chk({name, " rx_ready"},     {31'd0, rx_ready},   32'd0);
    chk({name, " words_loaded"}, 32'(words_loaded),   32'(exp_words));
    if (ok) begin
      if (exp_done)
        exp_done_cyc = (exp_words == 0) ? beat_q[1] + 1 : beat_q[4*exp_words+1] + 2;
      else
        exp_done_cyc = -1;
      chk({name, " release cycle"}, 32'(done_cyc), 32'(exp_done_cyc));
    end
    $display("[TB] %s: %0d bytes, %0d writes observed", name, stream_q.size(), wr_addr_q.size());
    hold_check(3, exp_words, exp_done, exp_err);
  endtask

  typedef struct {
    int n;
    int max_gap;
    bit exp_done;
    bit exp_err;
    int exp_words;
  } vec_t;

  vec_t vecs[8];

  task automatic load_test1_stream();
    stream_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
  endtask

  task automatic check_test1_words(input string name);
    if (wr_data_q.size() == 2) begin
      chk({name, " word0"}, wr_data_q[0], 32'h0010_0513);
      chk({name, " word1"}, wr_data_q[1], 32'h0020_0593);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d expected below 50000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    vecs[0] = '{1,   0, 1'b1, 1'b0, 1};
    vecs[1] = '{2,   5, 1'b1, 1'b0, 2};
    vecs[2] = '{0,   2, 1'b1, 1'b0, 0};
    vecs[3] = '{65,  0, 1'b0, 1'b1, 0};
    vecs[4] = '{64,  0, 1'b1, 1'b0, 64};
    vecs[5] = '{300, 3, 1'b0, 1'b1, 0};
    vecs[6] = '{17,  4, 1'b1, 1'b0, 17};
    vecs[7] = '{64,  2, 1'b1, 1'b0, 64};

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Known two-instruction image, back to back.
    apply_reset();
    load_test1_stream();
    run_check("t1", 0, 1'b1, 1'b0, 2);
    check_test1_words("t1");

    // After release, a persistent offer is never accepted and outputs stay.
    hold_check(10, 2, 1'b1, 1'b0);
    chk("t6 imem_addr",  32'(imem_addr), 32'd1);
    chk("t6 imem_wdata", imem_wdata,     32'h0020_0593);

    // Same image with idle gaps between bytes.
    apply_reset();
    load_test1_stream();
    run_check("t2", 5, 1'b1, 1'b0, 2);
    check_test1_words("t2");

    // Reset after five beats, then the full image again.
    apply_reset();
    load_test1_stream();
    send_n(5, 0, ok);
    repeat (2) begin @(posedge clk); #1; end
    chk("t5 partial writes", 32'(wr_addr_q.size()), 32'd0);
    chk("t5 partial cpu_reset", {31'd0, cpu_reset}, 32'd1);
    apply_reset();
    run_check("t5", 0, 1'b1, 1'b0, 2);
    check_test1_words("t5");

    // Table: header sizes including empty, oversize and full-depth images.
    foreach (vecs[k]) begin
      apply_reset();
      build_stream(vecs[k].n, vecs[k].exp_words);
      run_check($sformatf("vec%0d n=%0d", k, vecs[k].n), vecs[k].max_gap,
                vecs[k].exp_done, vecs[k].exp_err, vecs[k].exp_words);
      if (vecs[k].n == DEPTH && wr_addr_q.size() == DEPTH)
        chk("full last addr", 32'(wr_addr_q[DEPTH-1]), 32'(DEPTH - 1));
    end

    // Random legal images with random gaps.
    for (int r = 0; r < 4; r++) begin
      int n;
      n = int'($urandom_range(DEPTH, 1));
      apply_reset();
      build_stream(n, n);
      run_check($sformatf("rand%0d n=%0d", r, n), int'($urandom_range(3, 0)), 1'b1, 1'b0, n);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
